// File: rtl/jtframe_rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_rom_pkg
//  Description : Shared definitions for the tile ROM responders: the fetch
//                state encoding and the beat count of one 32-bit row.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_rom_pkg;

    // Fetch FSM states, two-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } rom_state_t;

    // A 32-bit row is delivered as two 16-bit beats, low half first
    localparam int BEATS  = 2;
    localparam int BEAT_W = $clog2(BEATS);

endpackage
`default_nettype wire

// File: rtl/jtframe_rom_tagbuf.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_rom_tagbuf
//  Description : One-entry tagged row buffer with hit compare.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                cs, addr      - lookup enable and address
//                inv           - clear the valid flag (wins over a write)
//                we, wtag,
//                wdata         - fill the entry
//                data, ok      - stored row and combinational hit flag
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_rom_tagbuf #(
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          inv,
    input  logic          we,
    input  logic [AW-1:0] wtag,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] data,
    output logic          ok
);

    logic [AW-1:0] r_tag;
    logic          r_valid;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (we) begin
                r_tag  <= wtag;
                r_data <= wdata;
            end
            // Invalidate has priority: a row landing during inv stays unusable
            if (inv)
                r_valid <= 1'b0;
            else if (we)
                r_valid <= 1'b1;
        end
    end

    assign data = r_data;
    assign ok   = cs & r_valid & (r_tag == addr);

endmodule
`default_nettype wire

// File: rtl/jtframe_tilerom_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_tilerom_rsp
//  Description : Tile ROM responder. Serves 32-bit tilemap row requests from a
//                one-entry buffer; misses fetch the row from SDRAM as a burst
//                of two 16-bit beats (low beat first).
//  Ports       : clk, rst_n              - clock, synchronous active-low reset
//                rom_cs, rom_addr        - tilemap request
//                rom_data, rom_ok        - buffered row and hit flag
//                inv                     - invalidate the buffer
//                sdram_req, sdram_addr   - registered fetch request / beat addr
//                sdram_ack, sdram_rdy,
//                sdram_din               - controller handshake and beat data
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_tilerom_rsp
    import jtframe_rom_pkg::*;
#(
    parameter int AW = 15,
    parameter int SW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    input  logic          inv,
    output logic          sdram_req,
    output logic [SW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_din
);

    rom_state_t    r_state;
    rom_state_t    w_next;
    logic          w_start;
    logic          w_lo_we;
    logic          w_hi_we;
    logic [AW-1:0] r_fa;
    logic [15:0]   r_lo;
    logic          r_req;
    logic [SW-1:0] r_saddr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic. A fetch in flight always runs to completion,
    // regardless of rom_cs, rom_addr or inv.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (rom_cs && !rom_ok) w_next = ST_REQ;
            ST_REQ:  if (sdram_ack)         w_next = ST_LO;
            ST_LO:   if (sdram_rdy)         w_next = ST_HI;
            ST_HI:   if (sdram_rdy)         w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output strobes decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        w_start = 1'b0;
        w_lo_we = 1'b0;
        w_hi_we = 1'b0;
        case (r_state)
            ST_IDLE: w_start = rom_cs & ~rom_ok;
            ST_LO:   w_lo_we = sdram_rdy;
            ST_HI:   w_hi_we = sdram_rdy;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch datapath. sdram_req is registered from the next state so it
    // rises with REQ entry and falls the cycle after ack is sampled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fa    <= '0;
            r_lo    <= '0;
            r_req   <= 1'b0;
            r_saddr <= '0;
        end else begin
            r_req <= (w_next == ST_REQ);
            if (w_start) begin
                r_fa    <= rom_addr;
                r_saddr <= {rom_addr, BEAT_W'(0)};
            end
            if (w_lo_we) begin
                r_lo    <= sdram_din;
                r_saddr <= {r_fa, BEAT_W'(1)};
            end
        end
    end

    assign sdram_req  = r_req;
    assign sdram_addr = r_saddr;

    // ------------------------------------------------------------------
    // Row buffer; the completed row is tagged with the fetched address,
    // even if the tilemap has moved on meanwhile.
    // ------------------------------------------------------------------
    jtframe_rom_tagbuf #(
        .AW (AW),
        .DW (32)
    ) u_tagbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (rom_cs),
        .addr  (rom_addr),
        .inv   (inv),
        .we    (w_hi_we),
        .wtag  (r_fa),
        .wdata ({sdram_din, r_lo}),
        .data  (rom_data),
        .ok    (rom_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_jtframe_tilerom_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_tilerom_rsp
//  Description : Directed self-checking bench for jtframe_tilerom_rsp. The
//                SDRAM controller side is driven cycle by cycle from the
//                stimulus so handshakes can be placed in any state.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_tilerom_rsp;

    localparam int AW = 15;
    localparam int SW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rom_cs = 1'b0;
    logic [AW-1:0] rom_addr = '0;
    logic [31:0]   rom_data;
    logic          rom_ok;
    logic          inv = 1'b0;
    logic          sdram_req;
    logic [SW-1:0] sdram_addr;
    logic          sdram_ack = 1'b0;
    logic          sdram_rdy = 1'b0;
    logic [15:0]   sdram_din = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtframe_tilerom_rsp #(
        .AW (AW),
        .SW (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .inv        (inv),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one burst from the REQ state: ack, low beat, high beat.
    task automatic do_fetch(input logic [15:0] a0, input logic [15:0] lo,
                            input logic [15:0] hi, input logic inv_hi);
        chk("req_high", {31'd0, sdram_req}, 32'd1);
        chk("addr_lo", {16'd0, sdram_addr}, {16'd0, a0});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("req_drop", {31'd0, sdram_req}, 32'd0);
        sdram_din = lo;
        sdram_rdy = 1'b1;
        tick();
        sdram_rdy = 1'b0;
        chk("addr_hi", {16'd0, sdram_addr}, {16'd0, 16'(a0 + 16'd1)});
        sdram_din = hi;
        sdram_rdy = 1'b1;
        inv       = inv_hi;
        tick();
        sdram_rdy = 1'b0;
        inv       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- 1. Reset ----------------
        rom_cs   = 1'b1;
        rom_addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ok",   {31'd0, rom_ok},    32'd0);
            chk("rst_data", rom_data,            32'd0);
            chk("rst_req",  {31'd0, sdram_req}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        do_fetch(16'h0000, 16'h2222, 16'h1111, 1'b0);
        chk("t1_data", rom_data, 32'h1111_2222);
        chk("t1_ok", {31'd0, rom_ok}, 32'd1);

        // ---------------- 2. Miss, then hit ----------------
        rom_addr = 15'h1234;
        #1;
        chk("t2_miss", {31'd0, rom_ok}, 32'd0);
        tick();
        tick();
        chk("t2_req_wait", {31'd0, sdram_req}, 32'd1);
        tick();
        do_fetch(16'h2468, 16'hBEEF, 16'hCAFE, 1'b0);
        chk("t2_data", rom_data, 32'hCAFE_BEEF);
        chk("t2_ok", {31'd0, rom_ok}, 32'd1);
        rom_addr = 15'h0000;
        #1;
        rom_addr = 15'h1234;
        #1;
        chk("t2_hit_same_cycle", {31'd0, rom_ok}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_req", {31'd0, sdram_req}, 32'd0);
        end

        // ---------------- 3. Address change mid-fetch ----------------
        rom_addr = 15'h0010;
        tick();
        chk("t3_req", {31'd0, sdram_req}, 32'd1);
        chk("t3_addr", {16'd0, sdram_addr}, 32'h0020);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_addr  = 15'h0011;
        sdram_din = 16'h0A0A;
        sdram_rdy = 1'b1;
        tick();
        sdram_din = 16'h0B0B;
        tick();
        sdram_rdy = 1'b0;
        chk("t3_stale_ok", {31'd0, rom_ok}, 32'd0);
        chk("t3_stale_data", rom_data, 32'h0B0B_0A0A);
        tick();
        do_fetch(16'h0022, 16'h3333, 16'h4444, 1'b0);
        chk("t3_ok", {31'd0, rom_ok}, 32'd1);
        chk("t3_data", rom_data, 32'h4444_3333);

        // ---------------- 4. Invalidate ----------------
        rom_addr = 15'h0100;
        tick();
        do_fetch(16'h0200, 16'h5555, 16'h6666, 1'b0);
        chk("t4_hit", {31'd0, rom_ok}, 32'd1);
        inv = 1'b1;
        tick();
        inv = 1'b0;
        chk("t4_inv_ok", {31'd0, rom_ok}, 32'd0);
        tick();
        do_fetch(16'h0200, 16'h7777, 16'h8888, 1'b1);
        chk("t4_inv_hi_ok", {31'd0, rom_ok}, 32'd0);
        chk("t4_inv_hi_data", rom_data, 32'h8888_7777);
        tick();
        do_fetch(16'h0200, 16'h9999, 16'hAAAA, 1'b0);
        chk("t4_refetch_ok", {31'd0, rom_ok}, 32'd1);

        // ---------------- 5. Reset mid-fetch ----------------
        rom_addr = 15'h0300;
        tick();
        chk("t5_addr", {16'd0, sdram_addr}, 32'h0600);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        sdram_din = 16'h1357;
        sdram_rdy = 1'b1;
        tick();
        sdram_rdy = 1'b0;
        rst_n  = 1'b0;
        rom_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_data", rom_data, 32'd0);
        chk("t5_rst_req", {31'd0, sdram_req}, 32'd0);
        sdram_din = 16'hDEAD;
        sdram_rdy = 1'b1;
        tick();
        sdram_rdy = 1'b0;
        chk("t5_stray_data", rom_data, 32'd0);
        chk("t5_stray_req", {31'd0, sdram_req}, 32'd0);
        rom_cs = 1'b1;
        tick();
        chk("t5_new_req", {31'd0, sdram_req}, 32'd1);
        sdram_rdy = 1'b1;
        tick();
        sdram_rdy = 1'b0;
        chk("t5_rdy_in_req", {31'd0, sdram_req}, 32'd1);
        do_fetch(16'h0600, 16'h5678, 16'h1234, 1'b0);
        chk("t5_data", rom_data, 32'h1234_5678);
        chk("t5_ok", {31'd0, rom_ok}, 32'd1);

        // ---------------- 6. Spurious handshake ----------------
        rom_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            chk("t6_ack_req", {31'd0, sdram_req}, 32'd0);
            sdram_din = 16'hFFFF;
            sdram_rdy = 1'b1;
            tick();
            sdram_rdy = 1'b0;
            chk("t6_rdy_req", {31'd0, sdram_req}, 32'd0);
            chk("t6_data", rom_data, 32'h1234_5678);
        end
        rom_cs = 1'b1;
        #1;
        chk("t6_hit", {31'd0, rom_ok}, 32'd1);
        tick();
        chk("t6_no_req", {31'd0, sdram_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
